// File: rtl/cpu_axi_master.sv
// cpu_axi_master
//   Upstream AXI master in front of the SRAM-side AXI slave bridge. Two
//   core-side clients share it: instruction fetch (read-only) and load/store
//   (read/write). Each accepted request becomes exactly one single-beat AXI
//   transaction, and only one transaction is in flight at any time.
//
//   Optional feature macro: AXI_MST_RESP_ERR_EN
//     defined   -> adds inst_err / data_err, registered alongside the client
//                  rvalid pulse (1 when rresp/bresp != OKAY)
//     undefined -> no error ports; rresp/bresp are ignored
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   inst_req/addr/ack             fetch request, held until inst_ack
//   inst_rvalid/rdata             one-cycle pulse with the fetched word
//   data_req/we/addr/wstrb/wdata  load/store request, held until data_ack
//   data_ack                      load/store accepted this cycle
//   data_rvalid/rdata             one-cycle pulse: load data / store done (rdata=0)
//   m_ar*, m_r*, m_aw*, m_w*, m_b* AXI master channels
//   inst_err, data_err            (AXI_MST_RESP_ERR_EN only) error flags
module cpu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // instruction fetch client
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_ack,
  output logic                  inst_rvalid,
  output logic [DATA_W-1:0]     inst_rdata,
  // load/store client
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_ack,
  output logic                  data_rvalid,
  output logic [DATA_W-1:0]     data_rdata,
  // AXI read address channel
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [ID_W-1:0]       m_arid,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arlock,
  output logic [3:0]            m_arcache,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  // AXI read data channel
  input  logic [ID_W-1:0]       m_rid,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  // AXI write address channel
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [ID_W-1:0]       m_awid,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic                  m_awlock,
  output logic [3:0]            m_awcache,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  // AXI write data channel
  output logic [ID_W-1:0]       m_wid,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  // AXI write response channel
  input  logic [ID_W-1:0]       m_bid,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready
`ifdef AXI_MST_RESP_ERR_EN
  ,
  output logic                  inst_err,
  output logic                  data_err
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              last_grant_data;   // 1: data client was granted last
  logic              grant_inst;
  logic              grant_data;

  logic [ADDR_W-1:0] cap_addr;
  logic              cap_is_data;       // owner of the in-flight transaction
  logic [STRB_W-1:0] cap_wstrb;
  logic [DATA_W-1:0] cap_wdata;

  logic              aw_done;
  logic              w_done;

  logic              ar_hs;
  logic              r_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;

  // Round robin: on contention the client that did not win last time wins.
  always_comb begin
    grant_inst = (state == S_IDLE) && inst_req && (!data_req || last_grant_data);
    grant_data = (state == S_IDLE) && data_req && !grant_inst;
  end

  assign inst_ack = grant_inst;
  assign data_ack = grant_data;

  // Valids are decoded from the state register, so they drop as soon as
  // aresetn clears the state and stay stable until their handshake.
  assign m_arvalid = (state == S_AR);
  assign m_rready  = (state == S_R);
  assign m_awvalid = (state == S_WR) && !aw_done;
  assign m_wvalid  = (state == S_WR) && !w_done;
  assign m_bready  = (state == S_B);

  assign ar_hs = m_arvalid && m_arready;
  assign r_hs  = m_rvalid  && m_rready;
  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid  && m_wready;
  assign b_hs  = m_bvalid  && m_bready;

  // Read and write channels carry the same captured request payload.
  assign m_araddr  = cap_addr;
  assign m_arid    = cap_is_data ? ID_W'(1) : '0;
  assign m_arlen   = '0;
  assign m_arsize  = AXI_SIZE;
  assign m_arburst = 2'b01;
  assign m_arlock  = 1'b0;
  assign m_arcache = '0;
  assign m_arprot  = '0;

  assign m_awaddr  = cap_addr;
  assign m_awid    = cap_is_data ? ID_W'(1) : '0;
  assign m_awlen   = '0;
  assign m_awsize  = AXI_SIZE;
  assign m_awburst = 2'b01;
  assign m_awlock  = 1'b0;
  assign m_awcache = '0;
  assign m_awprot  = '0;

  assign m_wid     = m_awid;
  assign m_wdata   = cap_wdata;
  assign m_wstrb   = cap_wstrb;
  assign m_wlast   = 1'b1;

  // Single-beat transactions: rid/rlast/bid carry no extra information.
  logic unused_ok;
`ifdef AXI_MST_RESP_ERR_EN
  assign unused_ok = ^{m_rid, m_rlast, m_bid};
`else
  assign unused_ok = ^{m_rid, m_rlast, m_bid, m_rresp, m_bresp};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_inst)      state_nxt = S_AR;
        else if (grant_data) state_nxt = data_we ? S_WR : S_AR;
      end
      S_AR:    if (ar_hs) state_nxt = S_R;
      S_R:     if (r_hs)  state_nxt = S_IDLE;
      // Either handshake may already be done or be happening this cycle.
      S_WR:    if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_B;
      S_B:     if (b_hs)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= S_IDLE;
      last_grant_data <= 1'b1;
      cap_addr        <= '0;
      cap_is_data     <= 1'b0;
      cap_wstrb       <= '0;
      cap_wdata       <= '0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      inst_rvalid     <= 1'b0;
      inst_rdata      <= '0;
      data_rvalid     <= 1'b0;
      data_rdata      <= '0;
`ifdef AXI_MST_RESP_ERR_EN
      inst_err        <= 1'b0;
      data_err        <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;

      if (grant_inst) begin
        last_grant_data <= 1'b0;
        cap_addr        <= inst_addr;
        cap_is_data     <= 1'b0;
        cap_wstrb       <= '0;
        cap_wdata       <= '0;
      end else if (grant_data) begin
        last_grant_data <= 1'b1;
        cap_addr        <= data_addr;
        cap_is_data     <= 1'b1;
        cap_wstrb       <= data_wstrb;
        cap_wdata       <= data_wdata;
      end

      // Done flags are cleared while idle so every WR visit starts fresh.
      if (state == S_IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == S_WR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end

      if (r_hs) begin
        if (cap_is_data) begin
          data_rvalid <= 1'b1;
          data_rdata  <= m_rdata;
`ifdef AXI_MST_RESP_ERR_EN
          data_err    <= (m_rresp != 2'b00);
`endif
        end else begin
          inst_rvalid <= 1'b1;
          inst_rdata  <= m_rdata;
`ifdef AXI_MST_RESP_ERR_EN
          inst_err    <= (m_rresp != 2'b00);
`endif
        end
      end

      if (b_hs) begin
        data_rvalid <= 1'b1;
        data_rdata  <= '0;
`ifdef AXI_MST_RESP_ERR_EN
        data_err    <= (m_bresp != 2'b00);
`endif
      end
    end
  end

endmodule

// File: tb/tb_cpu_axi_master.sv
// Testbench for cpu_axi_master: randomized fetch/load/store traffic against a
// randomized single-outstanding AXI slave, checked by a scoreboard fed from a
// transaction-level reference model (round-robin grant, byte-strobed memory).
module tb_cpu_axi_master;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;

  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_ack, inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_wdata = '0;
  logic        data_ack, data_rvalid;
  logic [31:0] data_rdata;

  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arlock;
  logic [3:0]  m_arcache;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [3:0]  m_rid = '0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rlast = 1'b0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awlock;
  logic [3:0]  m_awcache;
  logic [2:0]  m_awprot;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [3:0]  m_wid;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [3:0]  m_bid = '0;
  logic [1:0]  m_bresp = '0;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
`ifdef AXI_MST_RESP_ERR_EN
  logic        inst_err, data_err;
`endif

  // slave knobs, written only by the main process
  bit ar_block = 1'b0;
  bit r_block  = 1'b0;

  int total = 0;
  int bad   = 0;

  cpu_axi_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_ack(data_ack),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache),
    .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache),
    .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
`ifdef AXI_MST_RESP_ERR_EN
    , .inst_err(inst_err), .data_err(data_err)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- shared data definitions ----------------
  function automatic logic [31:0] default_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // slave answers SLVERR for addresses whose bits [7:4] are all ones
  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return (a[7:4] == 4'hF) ? 2'b10 : 2'b00;
  endfunction

  typedef struct {
    bit          is_data;
    logic [31:0] data;
    bit          err;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  // ---------------- reference model state (monitor-owned) ----------------
  rsp_t        exp_rsp[$];
  req_t        exp_ar[$];
  req_t        exp_aw[$];
  req_t        exp_w[$];
  logic [31:0] model_mem[logic [31:0]];
  bit          model_busy = 1'b0;
  bit          model_last_data = 1'b1;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : default_word(a);
  endfunction

  // ---------------- AXI slave BFM ----------------
  logic [31:0] slv_mem[logic [31:0]];

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : default_word(a);
  endfunction

  initial begin : slave
    bit          s_ar_hs, s_r_hs, s_aw_hs, s_w_hs, s_b_hs;
    logic [31:0] s_araddr, s_awaddr, s_wdata, tmp;
    logic [3:0]  s_arid, s_awid, s_wstrb;
    bit          r_pend, b_pend, aw_got, w_got;
    int          r_dly, b_dly;
    logic [31:0] aw_addr, w_data;
    logic [3:0]  w_strb, b_idh;
    forever begin
      @(negedge aclk);
      s_ar_hs = m_arvalid && m_arready;
      s_r_hs  = m_rvalid && m_rready;
      s_aw_hs = m_awvalid && m_awready;
      s_w_hs  = m_wvalid && m_wready;
      s_b_hs  = m_bvalid && m_bready;
      s_araddr = m_araddr; s_arid = m_arid;
      s_awaddr = m_awaddr; s_awid = m_awid;
      s_wdata  = m_wdata;  s_wstrb = m_wstrb;
      @(posedge aclk); #1;
      if (!aresetn) begin
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        m_arready = 0; m_awready = 0; m_wready = 0;
        m_rvalid = 0; m_bvalid = 0;
        continue;
      end
      if (s_ar_hs) begin
        r_pend = 1; r_dly = $urandom_range(0, 3);
        m_rdata = slv_rd(s_araddr); m_rresp = resp_of(s_araddr);
        m_rid = s_arid; m_rlast = 1'b1;
      end
      if (s_r_hs) begin r_pend = 0; m_rvalid = 0; end
      if (s_aw_hs) begin aw_got = 1; aw_addr = s_awaddr; b_idh = s_awid; end
      if (s_w_hs)  begin w_got = 1; w_data = s_wdata; w_strb = s_wstrb; end
      if (aw_got && w_got) begin
        tmp = slv_rd(aw_addr);
        for (int b = 0; b < 4; b++)
          if (w_strb[b]) tmp[b*8 +: 8] = w_data[b*8 +: 8];
        slv_mem[aw_addr] = tmp;
        aw_got = 0; w_got = 0;
        b_pend = 1; b_dly = $urandom_range(0, 3);
        m_bresp = resp_of(aw_addr); m_bid = b_idh;
      end
      if (s_b_hs) begin b_pend = 0; m_bvalid = 0; end
      m_arready = !ar_block && ($urandom_range(0, 3) != 0);
      m_awready = ($urandom_range(0, 2) != 0);
      m_wready  = ($urandom_range(0, 2) != 0);
      if (r_pend && !m_rvalid) begin
        if (r_dly == 0 && !r_block) m_rvalid = 1;
        else if (r_dly > 0) r_dly--;
      end
      if (b_pend && !m_bvalid) begin
        if (b_dly == 0) m_bvalid = 1;
        else b_dly--;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit          prev_ar_wait, prev_aw_wait, prev_w_wait, lat_rd, lat_wr;
    logic [31:0] prev_araddr, prev_awaddr, prev_wdata, tmp;
    logic [3:0]  prev_wstrb;
    bit          exp_i, exp_d;
    rsp_t        r;
    req_t        q;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        exp_rsp.delete(); exp_ar.delete(); exp_aw.delete(); exp_w.delete();
        model_busy = 0; model_last_data = 1;
        prev_ar_wait = 0; prev_aw_wait = 0; prev_w_wait = 0;
        lat_rd = 0; lat_wr = 0;
        continue;
      end

      // address/data valid one cycle after the accepting ack
      if (lat_rd) check("ar_latency", 64'(m_arvalid), 64'(1));
      if (lat_wr) begin
        check("aw_latency", 64'(m_awvalid), 64'(1));
        check("w_latency", 64'(m_wvalid), 64'(1));
      end
      lat_rd = 0; lat_wr = 0;

      // a raised valid keeps itself and its payload until the handshake
      if (prev_ar_wait) begin
        check("ar_hold", 64'(m_arvalid), 64'(1));
        check("araddr_hold", 64'(m_araddr), 64'(prev_araddr));
      end
      if (prev_aw_wait) begin
        check("aw_hold", 64'(m_awvalid), 64'(1));
        check("awaddr_hold", 64'(m_awaddr), 64'(prev_awaddr));
      end
      if (prev_w_wait) begin
        check("w_hold", 64'(m_wvalid), 64'(1));
        check("wdata_hold", 64'({m_wstrb, m_wdata}), 64'({prev_wstrb, prev_wdata}));
      end
      prev_ar_wait = m_arvalid && !m_arready; prev_araddr = m_araddr;
      prev_aw_wait = m_awvalid && !m_awready; prev_awaddr = m_awaddr;
      prev_w_wait  = m_wvalid && !m_wready;   prev_wdata = m_wdata; prev_wstrb = m_wstrb;

      if (m_arvalid && m_arready) begin
        check("ar_pending", 64'(exp_ar.size()), 64'(1));
        if (exp_ar.size() > 0) begin
          q = exp_ar.pop_front();
          check("araddr", 64'(m_araddr), 64'(q.addr));
          check("arid", 64'(m_arid), 64'(q.id));
        end
      end
      if (m_awvalid && m_awready) begin
        check("aw_pending", 64'(exp_aw.size()), 64'(1));
        if (exp_aw.size() > 0) begin
          q = exp_aw.pop_front();
          check("awaddr", 64'(m_awaddr), 64'(q.addr));
          check("awid", 64'(m_awid), 64'(q.id));
        end
      end
      if (m_wvalid && m_wready) begin
        check("w_pending", 64'(exp_w.size()), 64'(1));
        if (exp_w.size() > 0) begin
          q = exp_w.pop_front();
          check("wdata", 64'(m_wdata), 64'(q.wdata));
          check("wstrb", 64'(m_wstrb), 64'(q.wstrb));
          check("wid", 64'(m_wid), 64'(q.id));
        end
      end

      if (inst_rvalid || data_rvalid) begin
        check("rvalid_exclusive", 64'(inst_rvalid && data_rvalid), 64'(0));
        check("rsp_pending", 64'(exp_rsp.size()), 64'(1));
        if (exp_rsp.size() > 0) begin
          r = exp_rsp.pop_front();
          check("rsp_owner", 64'(data_rvalid), 64'(r.is_data));
          if (r.is_data) check("data_rdata", 64'(data_rdata), 64'(r.data));
          else           check("inst_rdata", 64'(inst_rdata), 64'(r.data));
`ifdef AXI_MST_RESP_ERR_EN
          if (r.is_data) check("data_err", 64'(data_err), 64'(r.err));
          else           check("inst_err", 64'(inst_err), 64'(r.err));
`endif
        end
        model_busy = 0;
      end

      // reference arbitration: idle master, round robin on contention
      exp_i = !model_busy && inst_req && (!data_req || model_last_data);
      exp_d = !model_busy && data_req && !exp_i;
      check("inst_ack", 64'(inst_ack), 64'(exp_i));
      check("data_ack", 64'(data_ack), 64'(exp_d));
      if (exp_i) begin
        model_busy = 1; model_last_data = 0;
        q = '{addr: inst_addr, id: 4'd0, wdata: 32'h0, wstrb: 4'h0};
        exp_ar.push_back(q);
        exp_rsp.push_back('{is_data: 1'b0, data: model_rd(inst_addr),
                            err: (resp_of(inst_addr) != 2'b00)});
        lat_rd = 1;
      end
      if (exp_d) begin
        model_busy = 1; model_last_data = 1;
        q = '{addr: data_addr, id: 4'd1, wdata: data_wdata, wstrb: data_wstrb};
        if (data_we) begin
          exp_aw.push_back(q); exp_w.push_back(q);
          tmp = model_rd(data_addr);
          for (int b = 0; b < 4; b++)
            if (data_wstrb[b]) tmp[b*8 +: 8] = data_wdata[b*8 +: 8];
          model_mem[data_addr] = tmp;
          exp_rsp.push_back('{is_data: 1'b1, data: 32'h0,
                              err: (resp_of(data_addr) != 2'b00)});
          lat_wr = 1;
        end else begin
          exp_ar.push_back(q);
          exp_rsp.push_back('{is_data: 1'b1, data: model_rd(data_addr),
                              err: (resp_of(data_addr) != 2'b00)});
          lat_rd = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Holds requests until acked, then waits for the scoreboard to drain.
  task automatic run_clients(input int max_cycles, output bit ok);
    logic ia, da;
    ok = 0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge aclk); ia = inst_ack; da = data_ack;
      @(posedge aclk); #1;
      if (ia) inst_req = 0;
      if (da) data_req = 0;
      if (!inst_req && !data_req && !model_busy && exp_rsp.size() == 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic random_traffic(input int cycles);
    logic ia, da;
    for (int c = 0; c < cycles; c++) begin
      @(negedge aclk); ia = inst_ack; da = data_ack;
      @(posedge aclk); #1;
      if (ia) inst_req = 0;
      if (da) data_req = 0;
      if (inst_req && $urandom_range(0, 39) == 0) inst_req = 0;
      else if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req  = 1;
        inst_addr = 32'h1C00_0000 | {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (data_req && $urandom_range(0, 39) == 0) data_req = 0;
      else if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req   = 1;
        data_we    = 1'($urandom_range(0, 1));
        data_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        data_wstrb = 4'($urandom_range(0, 15));
        data_wdata = $urandom();
      end
    end
  endtask

  initial begin : main
    bit ok;
    logic ia, seen_r;
    repeat (3) @(posedge aclk);
    #2 aresetn = 1;

    // reset state and tied constants
    @(negedge aclk);
    check("rst_arvalid", 64'(m_arvalid), 64'(0));
    check("rst_awvalid", 64'(m_awvalid), 64'(0));
    check("rst_wvalid", 64'(m_wvalid), 64'(0));
    check("rst_rready", 64'(m_rready), 64'(0));
    check("rst_bready", 64'(m_bready), 64'(0));
    check("rst_acks", 64'({inst_ack, data_ack}), 64'(0));
    check("rst_rvalids", 64'({inst_rvalid, data_rvalid}), 64'(0));
    check("rst_inst_rdata", 64'(inst_rdata), 64'(0));
    check("rst_data_rdata", 64'(data_rdata), 64'(0));
    check("tie_ar", 64'({m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot}),
          64'({8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0}));
    check("tie_aw", 64'({m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot}),
          64'({8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0}));
    check("tie_wlast", 64'(m_wlast), 64'(1));

    // single fetch
    @(posedge aclk); #1;
    inst_req = 1; inst_addr = 32'h1C00_0000;
    run_clients(100, ok); check("fetch_done", 64'(ok), 64'(1));

    // store, then read it back
    data_req = 1; data_we = 1; data_addr = 32'h10; data_wdata = 32'h1234_5678; data_wstrb = 4'hF;
    run_clients(100, ok); check("store_done", 64'(ok), 64'(1));
    data_req = 1; data_we = 0;
    run_clients(100, ok); check("load_done", 64'(ok), 64'(1));

    // simultaneous requests, twice: round robin decides each time
    for (int k = 0; k < 2; k++) begin
      inst_req = 1; inst_addr = 32'h1C00_0100;
      data_req = 1; data_we = 0; data_addr = 32'h20;
      run_clients(200, ok); check("contention_done", 64'(ok), 64'(1));
    end

    // address channel stalled: one ack only, arvalid held
    ar_block = 1;
    inst_req = 1; inst_addr = 32'h1C00_0040;
    data_req = 1; data_we = 0; data_addr = 32'h44;
    for (int c = 0; c < 2; c++) begin
      @(negedge aclk); ia = inst_ack || data_ack;
      @(posedge aclk); #1;
      if (inst_ack) inst_req = 0;
      if (data_ack) data_req = 0;
    end
    if (inst_req == 0) inst_req = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check("stall_arvalid", 64'(m_arvalid), 64'(1));
    end
    ar_block = 0;
    run_clients(300, ok); check("stall_done", 64'(ok), 64'(1));

    // reset while waiting for read data
    r_block = 1;
    inst_req = 1; inst_addr = 32'h1C00_0080;
    seen_r = 0;
    for (int c = 0; c < 50 && !seen_r; c++) begin
      @(negedge aclk); ia = inst_ack; seen_r = m_rready;
      @(posedge aclk); #1;
      if (ia) inst_req = 0;
    end
    check("reached_r", 64'(seen_r), 64'(1));
    #2 aresetn = 0;
    #1;
    check("mid_rst_rready", 64'(m_rready), 64'(0));
    check("mid_rst_valids", 64'({m_arvalid, m_awvalid, m_wvalid, m_bready}), 64'(0));
    repeat (3) @(posedge aclk);
    r_block = 0;
    #2 aresetn = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      check("no_pulse_after_rst", 64'(inst_rvalid), 64'(0));
    end
    @(posedge aclk); #1;
    inst_req = 1; inst_addr = 32'h1C00_00F0;
    run_clients(100, ok); check("post_rst_fetch", 64'(ok), 64'(1));

    // randomized traffic, then drain
    random_traffic(2500);
    inst_req = 0; data_req = 0;
    run_clients(300, ok); check("drain_done", 64'(ok), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
